fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  IF-stage front end: owns the PC, fetches from instruction memory over a req/gnt/rvalid handshake,
//  and buffers {pc_plus_4, instr} entries in a small FIFO in front of the IF/ID pipe register.
//  MEM-stage redirect (branch/jump/jr) flushes the queue and restarts fetch at the new PC.
//  ID backpressure (id_ready_i low) stalls fetch once the queue fills.
// PARAMETERS
//  DEPTH     4      prefetch FIFO entries (power of 2, >=2)
//  RESET_PC  32'h0  fetch address after reset
// PORTS
//  clk_i          in   1   clock; all state on rising edge
//  rst_i          in   1   synchronous reset, active-high
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch address (bits[1:0] always 0)
//  imem_gnt_i     in   1   request accepted this cycle
//  imem_rvalid_i  in   1   response valid (exactly one per granted request, >=1 cycle after gnt)
//  imem_rdata_i   in   32  instruction word
//  redirect_i     in   1   MEM-stage PC redirect
//  redirect_pc_i  in   32  new fetch PC (bits[1:0] ignored, forced 0)
//  id_valid_o     out  1   FIFO head valid
//  id_ready_i     in   1   IF/ID accepts head this cycle
//  id_pc_plus_4_o out  32  head entry fetch address + 4
//  id_instr_o     out  32  head entry instruction
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, FIFO empty, state S_REQ, imem_req_o=0, id_valid_o=0, id_* data=0.
//  At most one outstanding request. FSM:
//   S_REQ : imem_req_o = (count < DEPTH). On req&gnt: latch rsp_pc=fetch_pc, fetch_pc+=4, -> S_WAIT.
//   S_WAIT: req=0. On rvalid: push {rsp_pc+4, rdata}, -> S_REQ.
//   S_DROP: req=0. On rvalid: discard data, -> S_REQ.
//  Slot reservation: request issued only when count < DEPTH, so count(incl. in-flight) never exceeds DEPTH.
//  FIFO: first-word fall-through; id_valid_o = (count!=0); pop on id_valid_o & id_ready_i.
//   Push and pop in same cycle: count unchanged, data ordering preserved. Pointers wrap mod DEPTH.
//  Latency (1-cycle memory, gnt same cycle): req at cycle N -> id_valid_o with that instr at N+2.
//   Sustained throughput: one instruction per 2 cycles.
//  Redirect (highest priority, same-cycle effects):
//   - FIFO flushed (count=0, pointers reset); no pop counted that cycle even if id_ready_i high.
//   - fetch_pc <= {redirect_pc_i[31:2],2'b00}.
//   - S_REQ without gnt -> S_REQ; S_REQ with gnt -> S_DROP (granted response is stale).
//   - S_WAIT without rvalid -> S_DROP; S_WAIT with rvalid -> S_REQ, data not pushed.
//   - S_DROP without rvalid -> S_DROP; S_DROP with rvalid -> S_REQ.
//   - imem_req_o stays combinationally valid that cycle using pre-redirect fetch_pc; if granted, -> S_DROP.
//  Back-to-back redirects: each overrides fetch_pc; only the last is fetched.
//  fetch_pc wraps 32'hFFFF_FFFC -> 0 silently.
//  Reset mid-transaction: state forced to S_REQ, outstanding response afterwards is the memory's problem
//   (memory is reset on same rst_i and drops it).
// STRUCTURE
//  cpu_pkg: RESET_PC default, fetch FSM state encoding (S_REQ/S_WAIT/S_DROP), NOP word 32'h0.
//  Sub-module fetch_fifo (DEPTH, WIDTH=64; push/pop/flush, count, FWFT head); FSM + PC in top.
// TESTING
//  1 Reset, 1-cycle memory returning addr as data, id_ready_i=1 -> pc_plus_4 = 4,8,12 in order, every 2 cycles.
//  2 id_ready_i=0 for 20 cycles -> exactly DEPTH(4) entries, imem_req_o low once full; release -> no loss or duplicate.
//  3 redirect_i to 32'h100 while S_WAIT -> late rvalid dropped; next id entry pc_plus_4=32'h104.
//  4 redirect_i same cycle as gnt at 0x8 -> that response dropped; first entry after redirect_pc_i=0x40 is 0x44.
//  5 redirect_pc_i=32'h103 -> imem_addr_o=32'h100; FIFO full plus redirect with id_ready_i=1 -> id_valid_o=0 next cycle.
//  6 Random gnt/rvalid latency (1-5 cycles), random ready/redirect vs reference model -> stream matches, count<=DEPTH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: reset PC, fetch FSM encoding, NOP word.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through prefetch queue; flush clears occupancy and rewinds both pointers.
module fetch_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [AW:0]      count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF-stage front end: PC ownership, single-outstanding imem fetch FSM, and the prefetch queue.
module fetch_prefetch_unit
   import cpu_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_pc_plus_4_o,
   output logic [31:0] id_instr_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e    state, state_nxt;
   logic [31:0]     fetch_pc;
   logic [31:0]     rsp_pc;
   logic [31:0]     redirect_aligned;
   logic [CW-1:0]   count;
   logic [63:0]     head;
   logic            fire;
   logic            push;
   logic            pop;
   logic            valid;

   assign redirect_aligned = redirect_pc_i & ~32'h3;

   // A request is only issued with a free slot, so the in-flight word always has room.
   assign imem_req_o  = (state == S_REQ) && (count < CW'(DEPTH)) && !rst_i;
   assign imem_addr_o = fetch_pc;
   assign fire        = imem_req_o && imem_gnt_i;

   assign push  = (state == S_WAIT) && imem_rvalid_i && !redirect_i;
   assign valid = (count != '0);
   assign pop   = valid && id_ready_i && !redirect_i;

   assign id_valid_o     = valid;
   assign id_pc_plus_4_o = valid ? head[63:32] : 32'h0;
   assign id_instr_o     = valid ? head[31:0]  : NOP_WORD;

   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   if (fire) state_nxt = redirect_i ? S_DROP : S_WAIT;
         S_WAIT:  begin
            if (imem_rvalid_i)   state_nxt = S_REQ;
            else if (redirect_i) state_nxt = S_DROP;
         end
         S_DROP:  if (imem_rvalid_i) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         rsp_pc   <= 32'h0;
      end else begin
         state <= state_nxt;
         if (redirect_i)  fetch_pc <= redirect_aligned;
         else if (fire)   fetch_pc <= fetch_pc + 32'd4;
         if (fire)        rsp_pc   <= fetch_pc;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data ({rsp_pc + 32'd4, imem_rdata_i}),
      .pop       (pop),
      .flush     (redirect_i),
      .count     (count),
      .head      (head)
   );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboarded bench: instruction memory model, interface-level occupancy model, directed and random phases.
module tb_fetch_prefetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_pc_plus_4_o;
   logic [31:0] id_instr_o;

   always #5 clk = ~clk;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_gnt_i     (imem_gnt_i),
      .imem_rvalid_i  (imem_rvalid_i),
      .imem_rdata_i   (imem_rdata_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .id_valid_o     (id_valid_o),
      .id_ready_i     (id_ready_i),
      .id_pc_plus_4_o (id_pc_plus_4_o),
      .id_instr_o     (id_instr_o)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Instruction memory: returns the word address as data, configurable grant rate and latency.
   int gnt_pct = 100;
   int lat_min = 1;
   int lat_max = 1;
   bit          pend;
   logic [31:0] pend_addr;
   int          wait_c;

   initial begin
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; pend = 1'b0; wait_c = 0;
      forever begin
         @(posedge clk); #2;
         imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
         if (rst) pend = 1'b0;
         else begin
            if (pend) begin
               if (wait_c == 0) begin
                  imem_rvalid_i = 1'b1; imem_rdata_i = pend_addr; pend = 1'b0;
               end else wait_c--;
            end
            if (imem_req_o && !pend && ($urandom_range(99) < gnt_pct)) begin
               imem_gnt_i = 1'b1; pend = 1'b1; pend_addr = imem_addr_o;
               wait_c = int'($urandom_range(lat_max, lat_min)) - 1;
            end
         end
      end
   end

   // Reference: the ID stage must see consecutive words from the last restart point, and
   // occupancy equals fresh responses delivered minus entries handed over.
   int          occ = 0;
   bit          outst = 1'b0;
   bit          fresh = 1'b0;
   logic [31:0] next_fetch = 32'h0;
   logic [31:0] exp_q[$];
   int          cyc = 0;
   int          gnt_cnt = 0;
   int          pop_cyc[$];
   logic [31:0] pop_pc4[$];

   always @(negedge clk) begin
      logic        popv;
      logic [31:0] a;
      cyc++;
      if (rst) begin
         occ = 0; outst = 1'b0; fresh = 1'b0; next_fetch = 32'h0;
         exp_q.delete(); exp_q.push_back(32'h0);
      end else begin
         popv = id_valid_o && id_ready_i && !redirect_i;
         chk("id_valid", {31'h0, id_valid_o}, {31'h0, occ != 0});
         chk("imem_req", {31'h0, imem_req_o}, {31'h0, !outst && occ < DEPTH});
         if (imem_req_o) chk("imem_addr", imem_addr_o, next_fetch);
         if (popv) begin
            a = exp_q.pop_front();
            chk("id_pc_plus_4", id_pc_plus_4_o, a + 32'd4);
            chk("id_instr", id_instr_o, a);
            pop_cyc.push_back(cyc);
            pop_pc4.push_back(id_pc_plus_4_o);
         end
         if (redirect_i) occ = 0;
         else occ = occ + ((imem_rvalid_i && fresh) ? 1 : 0) - (popv ? 1 : 0);
         if (imem_rvalid_i) outst = 1'b0;
         if (imem_req_o && imem_gnt_i) begin
            outst = 1'b1; fresh = !redirect_i; gnt_cnt++; next_fetch = next_fetch + 32'd4;
         end
         if (redirect_i) begin
            fresh = 1'b0;
            next_fetch = redirect_pc_i & ~32'h3;
            exp_q.delete(); exp_q.push_back(next_fetch);
         end
      end
      while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_pops(input int n, input int budget, input string name);
      int k = 0;
      while (pop_pc4.size() < n && k < budget) begin tick(1); k++; end
      vectors++;
      if (pop_pc4.size() < n) begin
         miscompares++;
         $display("FAIL %s: got %0d handoffs expected %0d", name, pop_pc4.size(), n);
      end
   endtask

   int rel;

   task automatic do_reset();
      rst = 1'b1; redirect_i = 1'b0;
      tick(3);
      rst = 1'b0;
      rel = cyc + 1;
   endtask

   initial begin
      int n0, k, g0;
      id_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      @(negedge clk);
      chk("reset_req", {31'h0, imem_req_o}, 32'h0);
      chk("reset_valid", {31'h0, id_valid_o}, 32'h0);
      chk("reset_pc4", id_pc_plus_4_o, 32'h0);
      chk("reset_instr", id_instr_o, 32'h0);
      chk("reset_addr", imem_addr_o, 32'h0);

      // 1: in-order stream every other cycle
      @(posedge clk); #1;
      pop_cyc.delete(); pop_pc4.delete();
      do_reset();
      wait_pops(3, 20, "stream_timeout");
      if (pop_pc4.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("stream_pc4", pop_pc4[i], 32'(4 * (i + 1)));
            chk("stream_cycle", 32'(pop_cyc[i]), 32'(rel + 2 + 2 * i));
         end
      end

      // 2: backpressure fills exactly DEPTH entries
      id_ready_i = 1'b0;
      tick(20);
      chk("stall_req_low", {31'h0, imem_req_o}, 32'h0);
      chk("stall_valid", {31'h0, id_valid_o}, 32'h1);
      chk("stall_occupancy", 32'(occ), 32'(DEPTH));
      n0 = pop_pc4.size();
      id_ready_i = 1'b1;
      wait_pops(n0 + 4, 10, "drain_timeout");
      if (pop_pc4.size() >= n0 + 4)
         for (int i = 0; i < 3; i++) chk("drain_order", pop_pc4[n0 + i + 1], pop_pc4[n0 + i] + 32'd4);

      // 3: redirect while waiting on a slow response
      lat_min = 3; lat_max = 3;
      tick(4);
      g0 = gnt_cnt; k = 0;
      while (gnt_cnt == g0 && k < 20) begin tick(1); k++; end
      chk("wait_grant_seen", {31'h0, gnt_cnt != g0}, 32'h1);
      n0 = pop_pc4.size();
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      tick(1);
      redirect_i = 1'b0;
      wait_pops(n0 + 1, 30, "redir_wait_timeout");
      if (pop_pc4.size() > n0) chk("redir_wait_pc4", pop_pc4[n0], 32'h104);

      // 4: redirect in the same cycle as the grant at 0x8
      lat_min = 1; lat_max = 1;
      do_reset();
      k = 0;
      while (!(imem_req_o && imem_addr_o == 32'h8) && k < 20) begin tick(1); k++; end
      n0 = pop_pc4.size();
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      @(negedge clk);
      chk("gnt_at_8", {31'h0, imem_gnt_i}, 32'h1);
      chk("gnt_addr_8", imem_addr_o, 32'h8);
      @(posedge clk); #1;
      redirect_i = 1'b0;
      wait_pops(n0 + 1, 20, "redir_gnt_timeout");
      if (pop_pc4.size() > n0) chk("redir_gnt_pc4", pop_pc4[n0], 32'h44);

      // 5: misaligned redirect target, then flush of a full queue
      tick(1);
      redirect_i = 1'b1; redirect_pc_i = 32'h103;
      tick(1);
      redirect_i = 1'b0;
      chk("redirect_align", imem_addr_o, 32'h100);
      id_ready_i = 1'b0;
      tick(20);
      chk("full_before_flush", 32'(occ), 32'(DEPTH));
      id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
      tick(1);
      redirect_i = 1'b0;
      chk("flush_valid", {31'h0, id_valid_o}, 32'h0);
      chk("flush_pc4", id_pc_plus_4_o, 32'h0);

      // 6: random grant/latency/ready/redirect, including PC wrap
      gnt_pct = 70; lat_min = 1; lat_max = 5;
      for (int c = 0; c < 3000; c++) begin
         id_ready_i = ($urandom_range(3) != 0);
         redirect_i = ($urandom_range(39) == 0);
         if ($urandom_range(3) == 0) redirect_pc_i = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
         else                        redirect_pc_i = $urandom & 32'h0000_0FFF;
         tick(1);
      end
      redirect_i = 1'b0; id_ready_i = 1'b1; gnt_pct = 100;
      n0 = pop_pc4.size();
      tick(40);
      chk("final_progress", {31'h0, pop_pc4.size() > n0}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
